// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx -- I2S transmitter for a WM8731 DAC running in codec-slave mode.
//
// Runs entirely in the audio master clock domain (384*fs). It derives BCLK
// (64*fs) and LRCK (fs) and shifts out one left/right PCM pair per frame.
// The pair comes from a single-entry valid/ready pending register.
//
// Parameters:
//   W          sample width in bits, 16..24
//   BCLK_HALF  clk cycles per BCLK half-period (frame = 128*BCLK_HALF clks)
//
// Ports:
//   i_clk        audio master clock
//   i_rst        synchronous active-high reset
//   i_in_l/_r    left/right sample, two's complement
//   i_in_valid   sample pair present
//   o_in_ready   pending register empty
//   o_bclk       bit clock to the codec
//   o_lrck       LR clock to the codec (0 = left, 1 = right)
//   o_dacdat     serial data to the codec
//   o_underflow  one-cycle pulse when a frame starts with nothing pending
//
// Build option: define I2S_TX_HOLD_EN to replay the last pair on underflow;
// without it an underflow frame is silent.

module i2s_dac_tx #(
   parameter int W         = 16,
   parameter int BCLK_HALF = 3
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_in_l,
   input  logic [W-1:0] i_in_r,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   output logic         o_bclk,
   output logic         o_lrck,
   output logic         o_dacdat,
   output logic         o_underflow
);

   localparam int            DW       = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_HALF - 1);
   localparam logic [4:0]    W5       = 5'(W);

   logic [DW-1:0] r_div;
   logic          r_bclk;
   logic          r_lrck;
   logic          r_dacdat;
   logic          r_underflow;
   logic          r_pend_empty;
   logic [5:0]    r_b;
   logic [W-1:0]  r_pend_l, r_pend_r;
   logic [W-1:0]  r_word_l, r_word_r;

   logic          w_div_end;
   logic          w_tick;
   logic          w_frame;
   logic          w_xfer;
   logic [5:0]    w_b_nxt;
   logic [4:0]    w_p;
   logic [W-1:0]  w_word;
   logic [W-1:0]  w_sh;
   logic          w_slot_bit;

   assign w_div_end = (r_div == DIV_LAST);
   // Falling edge of BCLK: the divider wraps while BCLK is currently high.
   assign w_tick    = w_div_end & r_bclk;
   assign w_b_nxt   = r_b + 6'd1;
   assign w_frame   = w_tick & (r_b == 6'd63);
   assign w_xfer    = i_in_valid & r_pend_empty;

   // Slot p carries word bit W-p (one-BCLK I2S delay). At a frame start the
   // new slot is 0, which is always silent, so reading the pre-load words is
   // safe here.
   assign w_p        = w_b_nxt[4:0];
   assign w_word     = w_b_nxt[5] ? r_word_r : r_word_l;
   assign w_sh       = w_word >> (W5 - w_p);
   assign w_slot_bit = (w_p != 5'd0) && (w_p <= W5) && w_sh[0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_div        <= '0;
         r_bclk       <= 1'b0;
         r_lrck       <= 1'b1;
         r_dacdat     <= 1'b0;
         r_underflow  <= 1'b0;
         r_pend_empty <= 1'b1;
         r_b          <= 6'd63;
         r_pend_l     <= '0;
         r_pend_r     <= '0;
         r_word_l     <= '0;
         r_word_r     <= '0;
      end else begin
         r_underflow <= 1'b0;

         if (w_div_end) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
         end else begin
            r_div  <= r_div + DW'(1);
         end

         if (w_tick) begin
            r_b      <= w_b_nxt;
            r_lrck   <= w_b_nxt[5];
            r_dacdat <= w_slot_bit;
         end

         // Frame load uses the pre-edge pending state; a pair arriving on the
         // same edge waits for the next frame.
         if (w_frame) begin
            if (!r_pend_empty) begin
               r_word_l     <= r_pend_l;
               r_word_r     <= r_pend_r;
               r_pend_empty <= 1'b1;
            end else begin
               r_underflow  <= 1'b1;
`ifdef I2S_TX_HOLD_EN
               // Words keep their value: the last pair is replayed.
`else
               r_word_l     <= '0;
               r_word_r     <= '0;
`endif
            end
         end

         // Only possible while pending is empty, so never collides with the
         // frame consume above.
         if (w_xfer) begin
            r_pend_l     <= i_in_l;
            r_pend_r     <= i_in_r;
            r_pend_empty <= 1'b0;
         end
      end
   end

   assign o_in_ready  = r_pend_empty;
   assign o_bclk      = r_bclk;
   assign o_lrck      = r_lrck;
   assign o_dacdat    = r_dacdat;
   assign o_underflow = r_underflow;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Self-checking bench for i2s_dac_tx (W=16, BCLK_HALF=3).
// A time-based reference model predicts every output each cycle; table
// vectors and hand-written sequences cover reset release, the A5A5/8001
// frame, coincident transfer, underflow behaviour and mid-frame reset.

module tb_i2s_dac_tx;

   localparam int W  = 16;
   localparam int H  = 3;
   localparam int FR = 128 * H;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         valid = 1'b0;
   logic [W-1:0] l = '0, r = '0;
   logic         in_ready, bclk, lrck, dacdat, underflow;

   i2s_dac_tx #(.W(W), .BCLK_HALF(H)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_l      (l),
      .i_in_r      (r),
      .i_in_valid  (valid),
      .o_in_ready  (in_ready),
      .o_bclk      (bclk),
      .o_lrck      (lrck),
      .o_dacdat    (dacdat),
      .o_underflow (underflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Time since reset release determines clocks and slot; frame starts are
   // every FR cycles from cycle 2H, and decide which pair plays.
   int           m_n = 0;
   logic         m_full = 1'b0, m_uf = 1'b0, m_xfer = 1'b0;
   logic [W-1:0] m_pl = '0, m_pr = '0, m_wl = '0, m_wr = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_n = 0; m_full = 1'b0; m_uf = 1'b0; m_xfer = 1'b0;
         m_wl = '0; m_wr = '0;
      end else begin
         m_n++;
         m_uf   = 1'b0;
         m_xfer = valid && !m_full;
         if (m_n >= 2*H && ((m_n - 2*H) % FR) == 0) begin
            if (m_full) begin
               m_wl = m_pl; m_wr = m_pr; m_full = 1'b0;
            end else begin
               m_uf = 1'b1;
`ifdef I2S_TX_HOLD_EN
               m_wl = m_wl;
`else
               m_wl = '0; m_wr = '0;
`endif
            end
         end
         if (m_xfer) begin
            m_pl = l; m_pr = r; m_full = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      int b, p;
      logic [W-1:0] wd, sh;
      logic edac;
      b    = (63 + m_n / (2*H)) % 64;
      p    = b % 32;
      wd   = (b < 32) ? m_wl : m_wr;
      sh   = wd >> (W - p);
      edac = (p >= 1 && p <= W) ? sh[0] : 1'b0;
      chk("model_bclk",  32'(bclk),      32'((m_n / H) % 2));
      chk("model_lrck",  32'(lrck),      32'(b / 32));
      chk("model_dacdat",32'(dacdat),    32'(edac));
      chk("model_ready", 32'(in_ready),  32'(!m_full));
      chk("model_uflow", 32'(underflow), 32'(m_uf));
   end

   // ---------------- helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic goto(input int k);
      int g;
      g = 0;
      while (m_n < k && g < 100000) begin
         @(negedge clk);
         g++;
      end
      if (m_n < k) begin
         checks++; errors++;
         $display("FAIL goto_timeout got %0d expected %0d", m_n, k);
      end
   endtask

   // Called at slot 0 of a frame; samples each slot and ends at next slot 0.
   task automatic collect_frame(output logic [63:0] bits);
      for (int s = 0; s < 64; s++) begin
         bits[s] = dacdat;
         repeat (2*H) @(negedge clk);
      end
   endtask

   task automatic check_frame(input string nm, input logic [63:0] bits,
                              input logic [W-1:0] el, input logic [W-1:0] er);
      logic [W-1:0] lw, rw;
      int nz;
      nz = 0;
      for (int i = 1; i <= W; i++) begin
         lw[W-i] = bits[i];
         rw[W-i] = bits[32+i];
      end
      for (int s = 0; s < 64; s++)
         if (!((s >= 1 && s <= W) || (s >= 33 && s <= 32+W)) && bits[s]) nz++;
      chk({nm, "_left"},  32'(lw), 32'(el));
      chk({nm, "_right"}, 32'(rw), 32'(er));
      chk({nm, "_idle"},  32'(nz), 32'd0);
   endtask

   typedef struct {
      int   cyc;
      logic bclk, lrck, dac, uf, rdy;
   } vec_t;

   vec_t tv[$];
   logic [63:0] fb;
   logic [W-1:0] hl, hr;
   int nx, nuf;

   initial begin
      tv.push_back('{0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      tv.push_back('{1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      tv.push_back('{2,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      tv.push_back('{3,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      tv.push_back('{5,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
      tv.push_back('{6,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
      tv.push_back('{7,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      tv.push_back('{9,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
      tv.push_back('{12,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
      tv.push_back('{198, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
      tv.push_back('{390, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

      // Reset release with nothing offered.
      do_reset();
      foreach (tv[i]) begin
         goto(tv[i].cyc);
         chk($sformatf("tv%0d_bclk", tv[i].cyc),  32'(bclk),      32'(tv[i].bclk));
         chk($sformatf("tv%0d_lrck", tv[i].cyc),  32'(lrck),      32'(tv[i].lrck));
         chk($sformatf("tv%0d_dac", tv[i].cyc),   32'(dacdat),    32'(tv[i].dac));
         chk($sformatf("tv%0d_uflow", tv[i].cyc), 32'(underflow), 32'(tv[i].uf));
         chk($sformatf("tv%0d_ready", tv[i].cyc), 32'(in_ready),  32'(tv[i].rdy));
      end

      // A5A5/8001 pushed in cycle 2, then an underflow frame.
      do_reset();
      goto(1);
      chk("push_ready_c1", 32'(in_ready), 32'd1);
      valid = 1'b1; l = 16'hA5A5; r = 16'h8001;
      goto(2);
      valid = 1'b0;
      chk("push_ready_c2", 32'(in_ready), 32'd0);
      goto(5);
      chk("push_ready_c5", 32'(in_ready), 32'd0);
      goto(6);
      chk("push_uflow_c6", 32'(underflow), 32'd0);
      chk("push_ready_c6", 32'(in_ready), 32'd1);
      collect_frame(fb);
      check_frame("a5a5", fb, 16'hA5A5, 16'h8001);
      chk("uf_pulse_c390", 32'(underflow), 32'd1);
      collect_frame(fb);
`ifdef I2S_TX_HOLD_EN
      check_frame("uf_frame", fb, 16'hA5A5, 16'h8001);
`else
      check_frame("uf_frame", fb, 16'h0000, 16'h0000);
`endif

      // Transfer on the same edge as a frame start with pending empty.
      do_reset();
      goto(5);
      valid = 1'b1; l = 16'h3C5A; r = 16'h0FF0;
      goto(6);
      valid = 1'b0;
      chk("coinc_uflow", 32'(underflow), 32'd1);
      chk("coinc_ready", 32'(in_ready), 32'd0);
      collect_frame(fb);
      check_frame("coinc_f1", fb, 16'h0000, 16'h0000);
      chk("coinc_uflow_f2", 32'(underflow), 32'd0);
      collect_frame(fb);
      check_frame("coinc_f2", fb, 16'h3C5A, 16'h0FF0);

      // Reset at slot 20 while a second pair is pending.
      do_reset();
      goto(1);
      valid = 1'b1; l = 16'h1111; r = 16'h2222;
      goto(2);
      valid = 1'b0;
      goto(6);
      valid = 1'b1; l = 16'hFFFF; r = 16'hFFFF;
      goto(7);
      valid = 1'b0;
      chk("rst_pend_full", 32'(in_ready), 32'd0);
      goto(6 + 20*2*H);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_bclk",  32'(bclk),      32'd0);
      chk("rst_lrck",  32'(lrck),      32'd1);
      chk("rst_dac",   32'(dacdat),    32'd0);
      chk("rst_ready", 32'(in_ready),  32'd1);
      chk("rst_uflow", 32'(underflow), 32'd0);
      rst = 1'b0;
      goto(6);
      chk("rst_next_uflow", 32'(underflow), 32'd1);
      collect_frame(fb);
      chk("rst_discard", 32'(fb[31:0] | fb[63:32]), 32'd0);

      // Continuous valid with incrementing data: one transfer per frame.
      do_reset();
      hl = 16'(($urandom) & 16'hFFFF); hr = ~hl;
      valid = 1'b1; l = hl; r = hr;
      nx = 0; nuf = 0;
      while (m_n < 6 + 4*FR) begin
         @(negedge clk);
         if (underflow) nuf++;
         if (m_xfer) begin
            nx++; l = l + 16'd1; r = r + 16'd1;
         end
      end
      valid = 1'b0;
      chk("cont_xfers", 32'(nx),  32'd5);
      chk("cont_uflow", 32'(nuf), 32'd0);

      // Random valid/data; every cycle checked by the model.
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         valid = ($urandom_range(0, 3) != 0);
         l = 16'($urandom);
         r = 16'($urandom);
         @(negedge clk);
      end
      valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
